frame_sequencer: RTL and testbench

//  Frame-level scheduler for the AHB master. It owns read_enable and write_enable, so the master never reads and writes at once.
//  It alternates the master between read batches (pixel fetch into the read FIFO) and write bursts (Sobel results to dest).
//  It also handshakes with the Sobel core and counts output pixels until the frame is complete.

---
 rtl/frame_sequencer_if.sv | 28 ++
 rtl/frame_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - control/status bundle between config regs, AHB master, Sobel core and frame sequencer
interface frame_sequencer_if;
    logic        start;
    logic        abort;
    logic [15:0] length;
    logic [15:0] width;
    logic        transfer_data_complete_r;
    logic        transfer_data_complete_w;
    logic        sobel_valid;
    logic        read_enable;
    logic        write_enable;
    logic        sobel_start;
    logic        busy;
    logic        frame_done;
    logic        error;

    modport master (
        output start, abort, length, width,
        output transfer_data_complete_r, transfer_data_complete_w, sobel_valid,
        input  read_enable, write_enable, sobel_start, busy, frame_done, error
    );

    modport slave (
        input  start, abort, length, width,
        input  transfer_data_complete_r, transfer_data_complete_w, sobel_valid,
        output read_enable, write_enable, sobel_start, busy, frame_done, error
    );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame scheduler alternating AHB read batches, Sobel kicks and result write bursts
module frame_sequencer #(
    parameter int READS_PER_BATCH = 9,
    parameter int PIX_PER_WRITE   = 2,
    parameter int TIMEOUT         = 1023
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    frame_sequencer_if.slave ctrl
);
    localparam int              BW         = $clog2(READS_PER_BATCH + 1);
    localparam logic [BW-1:0]   BATCH_LAST = BW'(READS_PER_BATCH - 1);
    localparam logic [9:0]      WAIT_LAST  = 10'(TIMEOUT - 1);
    localparam logic [32:0]     PIX_STEP   = 33'(PIX_PER_WRITE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_KICK,
        S_WAIT_SOBEL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   length_q, length_d;
    logic [15:0]   width_q, width_d;
    logic [31:0]   pix_cnt_q, pix_cnt_d;
    logic [BW-1:0] batch_cnt_q, batch_cnt_d;
    logic [9:0]    wait_cnt_q, wait_cnt_d;
    logic          error_q, error_d;
    logic          read_en_q, read_en_d;
    logic          write_en_q, write_en_d;
    logic          sobel_start_q, sobel_start_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic [31:0]   total;
    logic [32:0]   pix_sum;
    logic [31:0]   pix_next;
    logic          geom_bad;
    logic          timed_out;
    logic          progress;
    logic          waiting;

    // Geometry below 3 wraps here, but such frames never leave IDLE for READ.
    assign total    = ({16'd0, width_q} - 32'd2) * ({16'd0, length_q} - 32'd2);
    assign pix_sum  = {1'b0, pix_cnt_q} + PIX_STEP;
    assign pix_next = pix_sum[32] ? 32'hFFFF_FFFF : pix_sum[31:0];
    assign geom_bad = (ctrl.width < 16'd3) || (ctrl.length < 16'd3);
    assign timed_out = (wait_cnt_q == WAIT_LAST);
    assign waiting  = (state_q == S_READ) || (state_q == S_WAIT_SOBEL) || (state_q == S_WRITE);

    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        width_d     = width_q;
        pix_cnt_d   = pix_cnt_q;
        batch_cnt_d = batch_cnt_q;
        error_d     = error_q;
        progress    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl.start) begin
                    length_d    = ctrl.length;
                    width_d     = ctrl.width;
                    pix_cnt_d   = '0;
                    batch_cnt_d = '0;
                    error_d     = geom_bad;
                    state_d     = geom_bad ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (ctrl.transfer_data_complete_r) begin
                    progress    = 1'b1;
                    batch_cnt_d = batch_cnt_q + 1'b1;
                    if (batch_cnt_q == BATCH_LAST) begin
                        state_d = S_KICK;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_KICK: begin
                state_d = S_WAIT_SOBEL;
            end
            S_WAIT_SOBEL: begin
                if (ctrl.sobel_valid) begin
                    state_d = S_WRITE;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (ctrl.transfer_data_complete_w) begin
                    progress  = 1'b1;
                    pix_cnt_d = pix_next;
                    // An odd total simply overshoots by one: the last word holds a single pixel.
                    if (pix_next >= total) begin
                        state_d = S_DONE;
                    end else begin
                        batch_cnt_d = '0;
                        state_d     = S_READ;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ctrl.abort) begin
            state_d     = S_IDLE;
            length_d    = length_q;
            width_d     = width_q;
            pix_cnt_d   = '0;
            batch_cnt_d = '0;
            error_d     = error_q;
        end

        wait_cnt_d = '0;
        if (waiting && (state_d == state_q) && !progress) begin
            wait_cnt_d = wait_cnt_q + 10'd1;
        end
    end

    // Enables follow the next state; read is held off one cycle after a write burst
    // so the master always sees a dead cycle between phases.
    always_comb begin
        read_en_d     = (state_d == S_READ) && !write_en_q;
        write_en_d    = (state_d == S_WRITE) && !read_en_q;
        sobel_start_d = (state_d == S_KICK);
        busy_d        = (state_d != S_IDLE);
        frame_done_d  = (state_d == S_DONE) && !error_d;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= S_IDLE;
            length_q      <= '0;
            width_q       <= '0;
            pix_cnt_q     <= '0;
            batch_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            error_q       <= 1'b0;
            read_en_q     <= 1'b0;
            write_en_q    <= 1'b0;
            sobel_start_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            length_q      <= length_d;
            width_q       <= width_d;
            pix_cnt_q     <= pix_cnt_d;
            batch_cnt_q   <= batch_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            error_q       <= error_d;
            read_en_q     <= read_en_d;
            write_en_q    <= write_en_d;
            sobel_start_q <= sobel_start_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign ctrl.read_enable  = read_en_q;
    assign ctrl.write_enable = write_en_q;
    assign ctrl.sobel_start  = sobel_start_q;
    assign ctrl.busy         = busy_q;
    assign ctrl.frame_done   = frame_done_q;
    assign ctrl.error        = error_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer with a reactive master/Sobel model
module tb_frame_sequencer;
    localparam int READS = 9;
    localparam int PIX   = 2;

    logic HCLK = 1'b0;
    logic HRESETn;

    frame_sequencer_if ifc();

    frame_sequencer dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .ctrl    (ifc)
    );

    always #5 HCLK = ~HCLK;

    int n_assert = 0;
    int n_fail   = 0;
    int n_read, n_write, n_kick, n_done;
    int overlap_cnt = 0;
    int gap_cnt     = 0;
    bit pending_v;
    int v_delay;
    logic prev_r = 1'b0;
    logic prev_w = 1'b0;

    always @(negedge HCLK) begin
        if (ifc.read_enable && ifc.write_enable) overlap_cnt = overlap_cnt + 1;
        if (ifc.read_enable && !prev_r && prev_w) gap_cnt = gap_cnt + 1;
        if (ifc.write_enable && !prev_w && prev_r) gap_cnt = gap_cnt + 1;
        prev_r <= ifc.read_enable;
        prev_w <= ifc.write_enable;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_writes(input int w, input int l);
        int total;
        total = (w - 2) * (l - 2);
        return (total + PIX - 1) / PIX;
    endfunction

    task automatic clear_counts();
        n_read = 0; n_write = 0; n_kick = 0; n_done = 0;
        pending_v = 1'b0; v_delay = 0;
    endtask

    task automatic zero_inputs();
        ifc.start = 1'b0; ifc.abort = 1'b0;
        ifc.transfer_data_complete_r = 1'b0;
        ifc.transfer_data_complete_w = 1'b0;
        ifc.sobel_valid = 1'b0;
    endtask

    // One clock of the environment: observe outputs at the falling edge, then drive pulses.
    task automatic cycle(input bit feed_sobel);
        @(negedge HCLK);
        if (ifc.frame_done) n_done++;
        zero_inputs();
        if (ifc.sobel_start) begin
            n_kick++;
            pending_v = 1'b1;
            v_delay   = $urandom_range(0, 3);
        end else if (pending_v && feed_sobel) begin
            if (v_delay == 0) begin
                ifc.sobel_valid = 1'b1;
                pending_v = 1'b0;
            end else begin
                v_delay--;
            end
        end
        if (ifc.read_enable) begin
            if ($urandom_range(0, 1) == 1) begin
                ifc.transfer_data_complete_r = 1'b1;
                n_read++;
            end
            if ($urandom_range(0, 3) == 0) ifc.transfer_data_complete_w = 1'b1;
            if ($urandom_range(0, 3) == 0) ifc.sobel_valid = 1'b1;
        end
        if (ifc.write_enable) begin
            if ($urandom_range(0, 1) == 1) begin
                ifc.transfer_data_complete_w = 1'b1;
                n_write++;
            end
            if ($urandom_range(0, 3) == 0) ifc.transfer_data_complete_r = 1'b1;
            if ($urandom_range(0, 3) == 0) ifc.sobel_valid = 1'b1;
        end
    endtask

    task automatic start_frame(input int w, input int l);
        @(negedge HCLK);
        zero_inputs();
        ifc.width  = 16'(w);
        ifc.length = 16'(l);
        ifc.start  = 1'b1;
    endtask

    task automatic run_frame(input int w, input int l, input int restart_at);
        int guard;
        string t;
        clear_counts();
        start_frame(w, l);
        guard = 0;
        do begin
            cycle(1);
            guard++;
            if (guard == restart_at) begin
                ifc.start  = 1'b1;
                ifc.width  = 16'd7;
                ifc.length = 16'd7;
            end
        end while (ifc.busy && guard < 5000);
        t = $sformatf("w%0d_l%0d", w, l);
        check({t, "_budget"}, guard < 5000, 1);
        check({t, "_writes"}, n_write, exp_writes(w, l));
        check({t, "_kicks"}, n_kick, exp_writes(w, l));
        check({t, "_reads"}, n_read, READS * exp_writes(w, l));
        check({t, "_frame_done"}, n_done, 1);
        check({t, "_error"}, ifc.error, 0);
    endtask

    initial begin
        int guard;
        int kick_at;
        int err_at;

        HRESETn = 1'b0;
        zero_inputs();
        ifc.width = 16'd0; ifc.length = 16'd0;
        clear_counts();
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        check("rst_read_enable", ifc.read_enable, 0);
        check("rst_write_enable", ifc.write_enable, 0);
        check("rst_sobel_start", ifc.sobel_start, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_frame_done", ifc.frame_done, 0);
        check("rst_error", ifc.error, 0);

        run_frame(4, 4, -1);
        run_frame(5, 4, -1);
        run_frame(3, 3, -1);
        run_frame(5, 5, -1);
        for (int i = 0; i < 4; i++) begin
            run_frame($urandom_range(3, 7), $urandom_range(3, 6), -1);
        end

        // Degenerate geometry goes straight to DONE with error.
        clear_counts();
        start_frame(2, 10);
        cycle(1);
        check("badgeo_error", ifc.error, 1);
        check("badgeo_busy_done", ifc.busy, 1);
        check("badgeo_no_read", ifc.read_enable, 0);
        cycle(1);
        check("badgeo_idle", ifc.busy, 0);
        check("badgeo_error_sticky", ifc.error, 1);
        check("badgeo_no_frame_done", n_done, 0);
        clear_counts();
        start_frame(10, 2);
        cycle(1);
        check("badgeo_len_error", ifc.error, 1);
        cycle(1);
        check("badgeo_len_no_frame_done", n_done, 0);

        // Sobel never answers: WAIT_SOBEL times out.
        clear_counts();
        start_frame(4, 4);
        guard = 0; kick_at = -1; err_at = -1;
        do begin
            cycle(0);
            guard++;
            if (n_kick == 1 && kick_at < 0) kick_at = guard;
            if (ifc.error && err_at < 0) err_at = guard;
        end while (ifc.busy && guard < 3000);
        check("timeout_error", ifc.error, 1);
        check("timeout_window", (kick_at > 0) && (err_at - kick_at >= 1020) && (err_at - kick_at <= 1030), 1);
        check("timeout_no_frame_done", n_done, 0);
        check("timeout_reads", n_read, READS);
        check("timeout_idle", ifc.busy, 0);
        repeat (3) cycle(1);
        check("timeout_error_sticky", ifc.error, 1);
        run_frame(3, 3, -1);

        // Abort in the middle of a write burst.
        clear_counts();
        start_frame(4, 4);
        guard = 0;
        do begin
            cycle(1);
            guard++;
        end while (!ifc.write_enable && guard < 500);
        check("abort_reached_write", ifc.write_enable, 1);
        ifc.transfer_data_complete_w = 1'b0;
        ifc.abort = 1'b1;
        cycle(1);
        check("abort_busy", ifc.busy, 0);
        check("abort_write_enable", ifc.write_enable, 0);
        check("abort_no_frame_done", n_done, 0);
        check("abort_error", ifc.error, 0);
        repeat (2) cycle(1);
        check("abort_stays_idle", ifc.busy, 0);

        // A second start with different geometry while busy must not retarget the frame.
        run_frame(4, 4, 5);

        // Asynchronous reset mid-READ.
        clear_counts();
        start_frame(4, 4);
        guard = 0;
        do begin
            cycle(1);
            guard++;
        end while (!ifc.read_enable && guard < 50);
        check("areset_reached_read", ifc.read_enable, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("areset_read_enable", ifc.read_enable, 0);
        check("areset_busy", ifc.busy, 0);
        check("areset_write_enable", ifc.write_enable, 0);
        check("areset_error", ifc.error, 0);
        zero_inputs();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        run_frame(4, 4, -1);

        check("enable_overlap", overlap_cnt, 0);
        check("enable_gap", gap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
